// File: rtl/video_timing_monitor.sv
// Passive receive-side checker for the parallel video bus.
// Recovers pixel coordinates, measures geometry and tracks lock.
module video_timing_monitor #(
  parameter int HDISP       = 800,
  parameter int VDISP       = 480,
  parameter int HTOTAL      = 928,
  parameter int VTOTAL      = 525,
  parameter int LOCK_FRAMES = 2,
  localparam int XW = $clog2(HDISP),
  localparam int YW = $clog2(VDISP)
) (
  input  logic          pixel_clk,
  input  logic          pixel_rst,
  input  logic          hs,
  input  logic          vs,
  input  logic          blank,
  input  logic [23:0]   rgb,
  input  logic          err_clr,
  output logic          pix_valid,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [23:0]   pix_rgb,
  output logic [11:0]   meas_htotal,
  output logic [11:0]   meas_hact,
  output logic [11:0]   meas_vtotal,
  output logic [11:0]   meas_vact,
  output logic [31:0]   frame_sum,
  output logic          frame_done,
  output logic          locked,
  output logic [3:0]    err
);

  typedef enum logic [1:0] {
    SEARCH,
    ACQUIRE,
    LOCKED
  } state_t;

  state_t      r_state, w_state_nx;
  logic        r_hs, r_vs, r_blank, r_hs_d, r_vs_d;
  logic [23:0] r_rgb;
  logic [11:0] r_clk_cnt, r_act_cnt, r_line_cnt, r_vact_cnt;
  logic [31:0] r_sum_acc;
  logic [3:0]  r_good, w_good_nx;
  logic        r_line_bad;

  logic        w_line_end, w_frame_end, w_pv, w_search, w_tmo;
  logic [11:0] w_clk_inc, w_act_inc, w_line_nx, w_vact_nx;
  logic [31:0] w_sum_nx;
  logic        w_e_ht, w_e_ha, w_e_vt, w_e_va, w_e_to;
  logic        w_line_err, w_frame_err, w_done;
  logic [3:0]  w_err_set;

  assign w_line_end  = r_hs_d & ~r_hs;
  assign w_frame_end = r_vs_d & ~r_vs;

  // The line-end cycle itself is counted as the last cycle of the old line
  assign w_clk_inc = (r_clk_cnt == 12'hFFF) ? r_clk_cnt : r_clk_cnt + 12'd1;
  assign w_act_inc = (r_blank && r_act_cnt != 12'hFFF) ?
                     r_act_cnt + 12'd1 : r_act_cnt;
  assign w_line_nx = (w_line_end && r_line_cnt != 12'hFFF) ?
                     r_line_cnt + 12'd1 : r_line_cnt;
  assign w_vact_nx = (w_line_end && w_act_inc != 12'd0 &&
                      r_vact_cnt != 12'hFFF) ?
                     r_vact_cnt + 12'd1 : r_vact_cnt;

  assign w_pv = r_blank && (r_act_cnt < 12'(HDISP)) &&
                (r_vact_cnt < 12'(VDISP));
  assign w_sum_nx = r_sum_acc + (w_pv ? {8'd0, r_rgb} : 32'd0);

  assign w_search = (r_state == SEARCH);
  assign w_tmo    = !w_line_end && (r_clk_cnt == 12'd4094);

  assign w_e_ht = w_line_end && !w_search && (w_clk_inc != 12'(HTOTAL));
  assign w_e_ha = w_line_end && !w_search && (w_act_inc != 12'd0) &&
                  (w_act_inc != 12'(HDISP));
  assign w_e_vt = w_frame_end && !w_search && (w_line_nx != 12'(VTOTAL));
  assign w_e_va = w_frame_end && !w_search && (w_vact_nx != 12'(VDISP));
  assign w_e_to = w_tmo && !w_search;

  assign w_line_err  = w_e_ht | w_e_ha;
  assign w_frame_err = w_e_vt | w_e_va;
  assign w_err_set   = {w_e_va | w_e_to, w_e_vt, w_e_ha, w_e_ht};

  assign locked = (r_state == LOCKED);

  always_comb begin
    w_state_nx = r_state;
    w_good_nx  = r_good;
    w_done     = 1'b0;
    unique case (r_state)
      SEARCH: begin
        w_good_nx = 4'd0;
        if (w_frame_end) w_state_nx = ACQUIRE;
      end
      ACQUIRE: begin
        if (w_tmo) begin
          w_state_nx = SEARCH;
          w_good_nx  = 4'd0;
        end else if (w_frame_end) begin
          w_done = 1'b1;
          if (r_line_bad || w_line_err || w_frame_err) begin
            w_good_nx = 4'd0;
          end else if (r_good + 4'd1 == 4'(LOCK_FRAMES)) begin
            w_good_nx  = 4'd0;
            w_state_nx = LOCKED;
          end else begin
            w_good_nx = r_good + 4'd1;
          end
        end
      end
      LOCKED: begin
        w_done = w_frame_end;
        if (w_line_err || w_frame_err || w_tmo) begin
          w_state_nx = SEARCH;
          w_good_nx  = 4'd0;
        end
      end
      default: begin
        w_state_nx = SEARCH;
        w_good_nx  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      r_hs        <= 1'b1;
      r_vs        <= 1'b1;
      r_hs_d      <= 1'b1;
      r_vs_d      <= 1'b1;
      r_blank     <= 1'b0;
      r_rgb       <= '0;
      r_clk_cnt   <= '0;
      r_act_cnt   <= '0;
      r_line_cnt  <= '0;
      r_vact_cnt  <= '0;
      r_sum_acc   <= '0;
      r_state     <= SEARCH;
      r_good      <= '0;
      r_line_bad  <= 1'b0;
      pix_valid   <= 1'b0;
      x           <= '0;
      y           <= '0;
      pix_rgb     <= '0;
      meas_htotal <= '0;
      meas_hact   <= '0;
      meas_vtotal <= '0;
      meas_vact   <= '0;
      frame_sum   <= '0;
      frame_done  <= 1'b0;
      err         <= '0;
    end else begin
      r_hs       <= hs;
      r_vs       <= vs;
      r_hs_d     <= r_hs;
      r_vs_d     <= r_vs;
      r_blank    <= blank;
      r_rgb      <= rgb;
      r_clk_cnt  <= w_line_end ? 12'd0 : w_clk_inc;
      r_act_cnt  <= w_line_end ? 12'd0 : w_act_inc;
      r_line_cnt <= w_frame_end ? 12'd0 : w_line_nx;
      r_vact_cnt <= w_frame_end ? 12'd0 : w_vact_nx;
      r_sum_acc  <= w_frame_end ? 32'd0 : w_sum_nx;
      if (w_line_end) begin
        meas_htotal <= w_clk_inc;
        meas_hact   <= w_act_inc;
      end
      if (w_frame_end) begin
        meas_vtotal <= w_line_nx;
        meas_vact   <= w_vact_nx;
        frame_sum   <= w_sum_nx;
      end
      pix_valid <= w_pv;
      pix_rgb   <= r_rgb;
      if (w_pv) begin
        x <= r_act_cnt[XW-1:0];
        y <= r_vact_cnt[YW-1:0];
      end
      r_state    <= w_state_nx;
      r_good     <= w_good_nx;
      r_line_bad <= (w_frame_end || w_search) ? 1'b0 :
                    (r_line_bad | w_line_err);
      frame_done <= w_done;
      err        <= (err & {4{~err_clr}}) | w_err_set;
    end
  end

endmodule

// File: tb/tb_video_timing_monitor.sv
// Scoreboard bench for video_timing_monitor on a reduced 20x8 raster.
// Stimulus pushes expected pixels/frames; monitors pop and compare.
`timescale 1ns/1ps
module tb_video_timing_monitor;
  localparam int HD = 20;
  localparam int VD = 8;
  localparam int HT = 28;
  localparam int VT = 12;
  localparam int LF = 2;

  logic        pixel_clk = 1'b0;
  logic        pixel_rst = 1'b1;
  logic        hs = 1'b1, vs = 1'b1, blank = 1'b0, err_clr = 1'b0;
  logic [23:0] rgb = '0;
  logic        pix_valid, frame_done, locked;
  logic [4:0]  x;
  logic [2:0]  y;
  logic [23:0] pix_rgb;
  logic [11:0] meas_htotal, meas_hact, meas_vtotal, meas_vact;
  logic [31:0] frame_sum;
  logic [3:0]  err;

  video_timing_monitor #(
    .HDISP(HD), .VDISP(VD), .HTOTAL(HT), .VTOTAL(VT), .LOCK_FRAMES(LF)
  ) dut (
    .pixel_clk(pixel_clk), .pixel_rst(pixel_rst),
    .hs(hs), .vs(vs), .blank(blank), .rgb(rgb), .err_clr(err_clr),
    .pix_valid(pix_valid), .x(x), .y(y), .pix_rgb(pix_rgb),
    .meas_htotal(meas_htotal), .meas_hact(meas_hact),
    .meas_vtotal(meas_vtotal), .meas_vact(meas_vact),
    .frame_sum(frame_sum), .frame_done(frame_done),
    .locked(locked), .err(err)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct packed {
    logic [23:0] rgb;
    logic [4:0]  x;
    logic [2:0]  y;
  } pix_t;

  typedef struct packed {
    logic [11:0] vt, va, ht, ha;
    logic [31:0] sum;
    logic        lk;
  } frm_t;

  pix_t        pq[$];
  frm_t        fq[$];
  pix_t        mp;
  frm_t        mf;
  int          checks = 0;
  int          errors = 0;
  bit          chk_pix = 1'b1;
  logic [31:0] acc = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pix"}, {pix_valid, x, y}, 0);
    chk({tag, "_rgb"}, pix_rgb, 0);
    chk({tag, "_meas_h"}, {meas_htotal, meas_hact}, 0);
    chk({tag, "_meas_v"}, {meas_vtotal, meas_vact}, 0);
    chk({tag, "_sum"}, frame_sum, 0);
    chk({tag, "_flags"}, {frame_done, locked, err}, 0);
  endtask

  always @(negedge pixel_clk) begin
    if (!pixel_rst && pix_valid && chk_pix) begin
      if (pq.size() == 0) begin
        chk("pix_unexpected", 1, 0);
      end else begin
        mp = pq.pop_front();
        chk("pix_x", x, mp.x);
        chk("pix_y", y, mp.y);
        chk("pix_rgb", pix_rgb, mp.rgb);
      end
    end
    if (!pixel_rst && frame_done) begin
      if (fq.size() == 0) begin
        chk("frame_done_unexpected", 1, 0);
      end else begin
        mf = fq.pop_front();
        chk("meas_vtotal", meas_vtotal, mf.vt);
        chk("meas_vact", meas_vact, mf.va);
        chk("meas_htotal_f", meas_htotal, mf.ht);
        chk("meas_hact_f", meas_hact, mf.ha);
        chk("frame_sum", frame_sum, mf.sum);
        chk("locked_at_done", locked, mf.lk);
      end
    end
  end

  task automatic cyc(input logic h, input logic v, input logic b,
                     input logic [23:0] d);
    hs = h; vs = v; blank = b; rgb = d;
    @(posedge pixel_clk);
    #1;
  endtask

  // mode 0 normal, 1 line 5 is 27 clocks, 2 line 4 has 21 active pixels
  task automatic frame(input int mode, input bit done, input bit lk,
                       input bit cst, input bit clr, input bit rmid);
    int          len, alast;
    logic        a, pulse;
    logic [23:0] d;
    if (done)
      fq.push_back('{vt: 12'(VT), va: 12'(VD), ht: 12'(HT), ha: 12'd0,
                     sum: acc, lk: lk});
    acc = '0;
    chk_pix = 1'b1;
    for (int l = 0; l < VT; l++) begin
      len   = (mode == 1 && l == 5) ? HT - 1 : HT;
      alast = (mode == 2 && l == 4) ? 26 : 25;
      for (int c = 0; c < len; c++) begin
        a = (l >= 3 && l <= 10 && c >= 6 && c <= alast);
        d = !a ? 24'h0 : cst ? 24'h000001 :
            {8'(l * 37 + 5), 8'(c * 11), 8'(8'hC0 | c)};
        if (a && chk_pix && (c - 6) < HD && (l - 3) < VD) begin
          pq.push_back('{rgb: d, x: 5'(c - 6), y: 3'(l - 3)});
          acc += {8'd0, d};
        end
        pulse = clr && l == 1 && c == 5;
        err_clr = pulse;
        cyc(!(c < 3), !(l < 2), a, d);
        err_clr = 1'b0;
        if (pulse) chk("err_clr", err, 0);
        if (l == 5 && c == 1) begin
          chk("meas_htotal_l4", meas_htotal, HT);
          chk("meas_hact_l4", meas_hact, (mode == 2) ? HD + 1 : HD);
          if (mode == 2) begin
            chk("err1_wide", err[1], 1);
            chk("unlock_wide", locked, 0);
          end
        end
        if (mode == 1 && l == 6 && c == 1) begin
          chk("meas_htotal_short", meas_htotal, HT - 1);
          chk("err0_short", err[0], 1);
          chk("unlock_short", locked, 0);
        end
        if (rmid && l == 5 && c == 10) begin
          #2 pixel_rst = 1'b1;
          chk_pix = 1'b0;
          pq.delete();
          #1 chk_zero("midrst");
          @(posedge pixel_clk);
          @(posedge pixel_clk);
          #1 pixel_rst = 1'b0;
        end
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge pixel_clk);
    #1 chk_zero("reset");
    pixel_rst = 1'b0;
    repeat (5) cyc(1'b1, 1'b1, 1'b0, 24'h0);

    frame(0, 0, 0, 1, 0, 0);
    frame(0, 1, 0, 0, 0, 0);
    chk("frame_sum_const", frame_sum, HD * VD);
    frame(0, 1, 1, 0, 0, 0);
    chk("locked_nominal", locked, 1);
    chk("err_nominal", err, 0);

    frame(1, 1, 1, 0, 0, 0);
    frame(0, 0, 0, 0, 0, 0);
    frame(0, 1, 0, 0, 0, 0);
    chk("err_sticky", err, 4'b0001);
    frame(0, 1, 1, 0, 1, 0);
    chk("relock_short", locked, 1);

    frame(2, 1, 1, 0, 0, 0);
    frame(0, 0, 0, 0, 0, 0);
    frame(0, 1, 0, 0, 0, 0);
    frame(0, 1, 1, 0, 1, 0);
    chk("relock_wide", locked, 1);

    repeat (5000) cyc(1'b1, 1'b1, 1'b0, 24'h0);
    chk("err_timeout", err, 4'b1000);
    chk("unlock_timeout", locked, 0);
    frame(0, 0, 0, 0, 0, 0);
    frame(0, 1, 0, 0, 0, 0);
    frame(0, 1, 1, 0, 0, 0);

    frame(0, 1, 1, 0, 0, 1);
    chk("search_after_rst", locked, 0);
    frame(0, 0, 0, 0, 0, 0);
    frame(0, 1, 0, 0, 0, 0);
    frame(0, 1, 1, 0, 0, 0);
    chk("relock_rst", locked, 1);

    repeat (10) cyc(1'b1, 1'b1, 1'b0, 24'h0);
    chk("pix_queue_drained", pq.size(), 0);
    chk("frame_queue_drained", fq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_timing_monitor.md
# video_timing_monitor

Receive-side checker for the parallel video bus (HS, VS, BLANK, RGB) driven by the display timing generator. It sits on the same pixel_clk domain as the generator and samples the bus passively. It recovers active-pixel coordinates, measures line and frame geometry, and checks that geometry against the expected format. It reports lock, sticky error flags and a per-frame pixel checksum for bench and on-chip self-test.

## Interface
- HDISP, 800, expected active pixels per line
- VDISP, 480, expected active lines per frame
- HTOTAL, 928, expected clocks per line (HDISP+HFP+HPULSE+HBP)
- VTOTAL, 525, expected lines per frame
- LOCK_FRAMES, 2, consecutive good frames required to assert lock (1..15)

- pixel_clk  in  1  clock; all logic on rising edge
- pixel_rst  in  1  reset, asynchronous, active-high
- hs  in  1  horizontal sync, active-low
- vs  in  1  vertical sync, active-low
- blank  in  1  1 = active pixel, 0 = blanking
- rgb  in  24  pixel data
- err_clr  in  1  synchronous clear of err[3:0]
- pix_valid  out  1  recovered active pixel strobe
- x  out  $clog2(HDISP)  column of current active pixel
- y  out  $clog2(VDISP)  row of current active pixel
- pix_rgb  out  24  rgb of current active pixel
- meas_htotal, meas_hact, meas_vtotal, meas_vact  out  12 each  last measured clocks/line, active pixels/line, lines/frame, active lines/frame
- frame_sum  out  32  sum of active rgb values of last complete frame, mod 2^32
- frame_done  out  1  one-cycle pulse when a frame measurement completes
- locked  out  1  geometry matches parameters
- err  out  4  sticky flags: [0] htotal, [1] hact, [2] vtotal, [3] vact/timeout

## Operation
- Input stage: hs, vs, blank and rgb are registered once. Edges are detected on the registered copies.
  - Line end = falling edge of registered hs.
  - Frame end = falling edge of registered vs.
- Line counters, reset at each line end:
  - clk_cnt counts every cycle.
  - act_cnt counts blank=1 cycles.
  - Both are 12-bit and saturate at 4095.
- At each line end:
  - meas_htotal <= clk_cnt; meas_hact <= act_cnt.
  - Increment line_cnt. If act_cnt ≠ 0, also increment vact_cnt.
  - Both 12-bit, saturating.
- Frame counters reset at each frame end: line_cnt, vact_cnt, sum_acc.
- At each frame end:
  - meas_vtotal <= line_cnt; meas_vact <= vact_cnt.
  - frame_sum <= sum_acc.
  - If a line end occurs in the same cycle, that line is accumulated first and counts in the closing frame.
- Coordinates:
  - x = act_cnt before increment. y = vact_cnt.
  - pix_valid = registered blank, except it is forced 0 when act_cnt ≥ HDISP or vact_cnt ≥ VDISP. x and y therefore never exceed HDISP-1 / VDISP-1.
  - pix_rgb = registered rgb.
  - sum_acc adds the full 24-bit rgb, zero-extended, for every pix_valid pixel.
- Line check, at each line end outside SEARCH:
  - meas_htotal ≠ HTOTAL → err[0].
  - act_cnt ∉ {0, HDISP} → err[1].
- Frame check, at each frame end outside SEARCH:
  - line_cnt ≠ VTOTAL → err[2].
  - vact_cnt ≠ VDISP → err[3].
- Timeout: clk_cnt reaching 4095, i.e. no hs fall, sets err[3] unless in SEARCH and forces the FSM to SEARCH.
- err bits are sticky. err_clr clears them. A set event in the same cycle as err_clr wins.
- FSM:
  - SEARCH: locked=0, good=0. First frame end → ACQUIRE. No frame_done on this edge.
  - ACQUIRE: at each frame end, pulse frame_done.
    - If no line or frame error occurred since the previous frame end, increment good.
    - Otherwise set good=0 and stay in ACQUIRE.
    - When good reaches LOCK_FRAMES → LOCKED.
  - LOCKED: locked=1. Pulse frame_done at each frame end. Any line, frame or timeout error → SEARCH, and locked drops the next cycle.

## Timing
- Latency: an input sampled at edge k produces pix_valid/x/y/pix_rgb at edge k+1.
- meas_htotal/meas_hact update one edge after the registered hs fall; meas_vtotal, meas_vact and frame_sum likewise after the registered vs fall.
- frame_done is high for exactly one cycle, coincident with the frame_sum update.
- locked rises in the same cycle as the frame_done that completes the LOCK_FRAMES-th good frame.
- Reset values:
  - All counters and measurements 0; frame_sum 0, err 0.
  - pix_valid, frame_done and locked 0; x, y and pix_rgb 0.
  - FSM in SEARCH.
  - Input registers: hs=1, vs=1, blank=0, so no false edge is seen after reset.
- Reset mid-frame: all state is lost; the next vs fall only re-enters ACQUIRE.

## Test plan
- Nominal 800x480 stream, HTOTAL=928, VTOTAL=525 → frame_done at 2nd and 3rd vs falls; locked=1 at 3rd; meas values 928/800/525/480; err=0.
- Constant rgb=24'h000001 on all active pixels, locked → frame_sum=384000. Check x runs 0..799 and y runs 0..479, with pix_valid count 384000 per frame.
- One line shortened to 927 clocks while locked → err[0]=1 and locked=0 within one cycle of that line end. After clean frames, relock on the 3rd subsequent frame end. err_clr → err=0.
- One line with 801 active cycles → err[1]=1; pix_valid not asserted for the 801st pixel; x stays ≤799.
- hs held high for 5000 cycles while locked → err[3]=1, locked=0, FSM in SEARCH.
- pixel_rst pulsed mid-frame while locked → all outputs 0 immediately. The first vs fall after release gives no frame_done; locked returns after LOCK_FRAMES further good frames.
